// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//
// Purpose:
//   Lets the EXU (port A) and LSU (port B) writeback stages share the single
//   register-file write port. Contention is resolved round-robin, and the
//   write port is driven from registers one cycle after the handshake. A
//   per-register busy scoreboard tells decode which registers still have a
//   write in flight, so it can stall on read-after-write hazards.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   a_valid/a_addr/a_data    port A write request (EXU results)
//   a_ready                  port A granted this cycle (combinational)
//   b_valid/b_addr/b_data    port B write request (LSU load data)
//   b_ready                  port B granted this cycle (combinational)
//   issue_valid/issue_addr   decode issued an instruction that writes issue_addr
//   raddr1/raddr2            decode source registers
//   rs1_busy/rs2_busy        source register has a pending write (combinational)
//   wen/waddr/wdata          register-file write port (registered)
module rf_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_data,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_addr,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata
);

  localparam int NREG = 2 ** ADDR_WIDTH;

  logic                  last_b_p1;
  logic                  a_grant;
  logic                  b_grant;
  logic                  hs;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  logic                  wen_p1;
  logic [ADDR_WIDTH-1:0] waddr_p1;
  logic [DATA_WIDTH-1:0] wdata_p1;

  logic [NREG-1:0]       busy_p1;
  logic [NREG-1:0]       busy_nxt;

  // ---- stage p0: combinational round-robin grant and request select ----
  // A wins when it is alone or when B was granted last; B takes every
  // remaining case where it is valid, so the two grants are exclusive.
  always_comb begin
    a_grant  = a_valid && (!b_valid || last_b_p1);
    b_grant  = b_valid && !a_grant;
    hs       = a_grant || b_grant;
    sel_addr = a_grant ? a_addr : b_addr;
    sel_data = a_grant ? a_data : b_data;
  end

  assign a_ready = a_grant;
  assign b_ready = b_grant;

  // ---- stage p1: registered write-port drive and grant pointer ----
  // A write to x0 still completes the handshake and updates waddr/wdata,
  // but never raises wen.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_b_p1 <= 1'b1;
      wen_p1    <= 1'b0;
      waddr_p1  <= '0;
      wdata_p1  <= '0;
    end else begin
      if (hs) begin
        last_b_p1 <= b_grant;
        wen_p1    <= (sel_addr != '0);
        waddr_p1  <= sel_addr;
        wdata_p1  <= sel_data;
      end else begin
        wen_p1    <= 1'b0;
      end
    end
  end

  assign wen   = wen_p1;
  assign waddr = waddr_p1;
  assign wdata = wdata_p1;

  // ---- scoreboard: clear on the commit cycle, set on issue ----
  // The set is applied after the clear so a new pending write to the same
  // register survives the commit of the older one. Bit 0 is forced low.
  always_comb begin
    busy_nxt = busy_p1;
    if (wen_p1) busy_nxt[waddr_p1] = 1'b0;
    if (issue_valid && (issue_addr != '0)) busy_nxt[issue_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_p1 <= '0;
    else     busy_p1 <= busy_nxt;
  end

  assign rs1_busy = busy_p1[raddr1];
  assign rs2_busy = busy_p1[raddr2];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, b_valid, a_ready, b_ready;
  logic [AW-1:0] a_addr, b_addr, issue_addr, raddr1, raddr2, waddr;
  logic [DW-1:0] a_data, b_data, wdata;
  logic          issue_valid, rs1_busy, rs2_busy, wen;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .raddr1(raddr1), .raddr2(raddr2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wen(wen), .waddr(waddr), .wdata(wdata)
  );

  typedef struct {
    int            cyc;
    bit            wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t expq[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: which requests the rules grant, which registers have a
  // write outstanding, and what the write port must show in the next cycle.
  bit            m_ok = 0;
  bit            m_last_b = 1;
  bit            pend [NREG];
  bit            cur_wen = 0;
  logic [AW-1:0] cur_addr = '0;
  bit            ga = 0, gb = 0;
  int            mon_start = -1;
  int            grant_log[$];

  always @(negedge clk) begin : model
    wr_t           e;
    logic [AW-1:0] ad;
    logic [DW-1:0] da;
    bit            exp_a, exp_b;
    if (rst === 1'b1) begin
      foreach (pend[i]) pend[i] = 0;
      m_last_b = 1;
      cur_wen  = 0;
      ga = 0; gb = 0;
      e.cyc = cyc + 1; e.wen = 0; e.addr = '0; e.data = '0;
      expq.push_back(e);
      if (!m_ok) mon_start = cyc + 1;
      m_ok = 1;
    end else if (m_ok) begin
      if (a_valid && b_valid) begin
        exp_a = m_last_b;
        exp_b = !m_last_b;
      end else begin
        exp_a = a_valid;
        exp_b = b_valid;
      end
      chk("a_ready", a_ready, exp_a);
      chk("b_ready", b_ready, exp_b);
      chk("rs1_busy", rs1_busy, pend[raddr1]);
      chk("rs2_busy", rs2_busy, pend[raddr2]);
      ga = exp_a; gb = exp_b;
      ad = exp_a ? a_addr : b_addr;
      da = exp_a ? a_data : b_data;
      if (ga || gb) begin
        e.cyc = cyc + 1; e.wen = (ad != 0); e.addr = ad; e.data = da;
        expq.push_back(e);
        m_last_b = gb;
        grant_log.push_back(gb ? 1 : 0);
      end
      if (cur_wen) pend[cur_addr] = 0;
      if (issue_valid && issue_addr != 0) pend[issue_addr] = 1;
      cur_wen  = (ga || gb) && (ad != 0);
      cur_addr = ad;
    end
  end

  // Monitor: compares the write port every cycle against the scoreboard.
  logic [AW-1:0] h_addr = '0;
  logic [DW-1:0] h_data = '0;

  always @(negedge clk) begin : monitor
    wr_t e;
    if (mon_start >= 0 && cyc >= mon_start) begin
      if (expq.size() > 0 && expq[0].cyc == cyc) begin
        e = expq.pop_front();
        chk("wen", wen, e.wen);
        chk("waddr", waddr, e.addr);
        chk("wdata", wdata, e.data);
        h_addr = e.addr;
        h_data = e.data;
      end else begin
        chk("wen_idle", wen, 0);
        chk("waddr_hold", waddr, h_addr);
        chk("wdata_hold", wdata, h_data);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : driver
    int g0;
    rst = 1; a_valid = 0; b_valid = 0; a_addr = '0; b_addr = '0;
    a_data = '0; b_data = '0; issue_valid = 0; issue_addr = '0;
    raddr1 = '0; raddr2 = '0;
    tick(); tick();
    rst = 0;

    // Single A write to x5
    a_valid = 1; a_addr = 5; a_data = 32'h1234;
    #1 chk("d1_a_ready", a_ready, 1);
    tick();
    a_valid = 0;
    chk("d1_wen", wen, 1); chk("d1_waddr", waddr, 5); chk("d1_wdata", wdata, 32'h1234);
    tick();
    chk("d1_wen_off", wen, 0);

    // Sustained contention after reset: A,B,A,B
    rst = 1; tick(); rst = 0;
    a_valid = 1; a_addr = 3; a_data = 32'hA0;
    b_valid = 1; b_addr = 4; b_data = 32'hB0;
    g0 = grant_log.size();
    for (int k = 0; k < 4; k++) begin
      tick();
      if (ga) a_data = a_data + 1;
      if (gb) b_data = b_data + 1;
      chk("d2_wen", wen, 1);
      chk("d2_waddr", waddr, (k % 2 == 0) ? 3 : 4);
    end
    a_valid = 0; b_valid = 0;
    for (int k = 0; k < 4; k++) chk("d2_order", grant_log[g0+k], k % 2);

    // Busy lifetime of x7
    issue_valid = 1; issue_addr = 7; raddr1 = 7;
    tick();
    issue_valid = 0;
    b_valid = 1; b_addr = 7; b_data = 32'h77;
    #1 chk("d3_busy_n", rs1_busy, 1);
    tick();
    b_valid = 0;
    #1 chk("d3_busy_n1", rs1_busy, 1);
    tick();
    #1 chk("d3_busy_n2", rs1_busy, 0);

    // Set and clear of x9 in the same cycle
    a_valid = 1; a_addr = 9; a_data = 32'h99; raddr2 = 9;
    tick();
    a_valid = 0; issue_valid = 1; issue_addr = 9;
    chk("d4_wen", wen, 1);
    tick();
    issue_valid = 0;
    #1 chk("d4_busy", rs2_busy, 1);
    tick();
    #1 chk("d4_busy_later", rs2_busy, 1);

    // Write to x0 and issue to x0
    a_valid = 1; a_addr = 0; a_data = 32'hFFFF;
    issue_valid = 1; issue_addr = 0; raddr1 = 0;
    #1 chk("d5_a_ready", a_ready, 1);
    tick();
    a_valid = 0; issue_valid = 0;
    chk("d5_wen", wen, 0); chk("d5_waddr", waddr, 0); chk("d5_wdata", wdata, 32'hFFFF);
    #1 chk("d5_busy0", rs1_busy, 0);

    // Reset during a pending A request
    issue_valid = 1; issue_addr = 1;
    tick();
    issue_addr = 2;
    tick();
    issue_valid = 0; raddr1 = 1; raddr2 = 2;
    #1 chk("d6_busy1", rs1_busy, 1); chk("d6_busy2", rs2_busy, 1);
    a_valid = 1; a_addr = 1; a_data = 32'h11; rst = 1;
    tick();
    rst = 0;
    chk("d6_wen", wen, 0);
    b_valid = 1; b_addr = 4; b_data = 32'h44;
    #1 chk("d6_rs1", rs1_busy, 0); chk("d6_rs2", rs2_busy, 0);
    chk("d6_a_first", a_ready, 1); chk("d6_b_wait", b_ready, 0);
    tick();
    a_valid = 0;
    tick();
    b_valid = 0;
    tick();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [AW-1:0] ia;
      rst = ($urandom_range(0, 199) == 0);
      if (!a_valid || ga) begin
        a_valid = ($urandom_range(0, 2) != 0);
        a_addr  = ($urandom_range(0, 9) == 0) ? '0 : AW'($urandom);
        a_data  = $urandom;
      end
      if (!b_valid || gb) begin
        b_valid = ($urandom_range(0, 2) != 0);
        b_addr  = ($urandom_range(0, 9) == 0) ? '0 : AW'($urandom);
        b_data  = $urandom;
      end
      ia = AW'($urandom);
      issue_addr  = ia;
      issue_valid = ($urandom_range(0, 3) == 0) && !pend[ia];
      raddr1 = AW'($urandom);
      raddr2 = AW'($urandom);
      tick();
    end
    rst = 0; a_valid = 0; b_valid = 0; issue_valid = 0;
    tick(); tick(); tick();
    chk("drain", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: port A (EXU results) and port B (LSU load data).
- Uses round-robin arbitration, a registered write-port drive, and a per-register busy scoreboard.
- The scoreboard lets decode stall on read-after-write hazards.
- Sits between the EXU/LSU writeback stages and the register file's wen/waddr/wdata inputs.

Parameters:
- ADDR_WIDTH, 5, register address width; the register count is 2**ADDR_WIDTH.
- DATA_WIDTH, 32, write data width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- a_valid  input  1  port A write request.
- a_ready  output  1  port A granted this cycle (combinational).
- a_addr  input  ADDR_WIDTH  port A destination register.
- a_data  input  DATA_WIDTH  port A write data.
- b_valid  input  1  port B write request.
- b_ready  output  1  port B granted this cycle (combinational).
- b_addr  input  ADDR_WIDTH  port B destination register.
- b_data  input  DATA_WIDTH  port B write data.
- issue_valid  input  1  decode issues an instruction that will write issue_addr.
- issue_addr  input  ADDR_WIDTH  destination register of the issued instruction.
- raddr1  input  ADDR_WIDTH  decode source register 1.
- raddr2  input  ADDR_WIDTH  decode source register 2.
- rs1_busy  output  1  raddr1 has a pending write (combinational).
- rs2_busy  output  1  raddr2 has a pending write (combinational).
- wen  output  1  register file write enable (registered).
- waddr  output  ADDR_WIDTH  register file write address (registered).
- wdata  output  DATA_WIDTH  register file write data (registered).

Behaviour:
- Reset (rst=1 at a clk edge):
  - wen=0, waddr=0, wdata=0.
  - All busy bits cleared.
  - Last-grant pointer set to B, so A wins the first contention.
  - Reset has priority over every other event in the same cycle; in-flight requests are dropped.
- Arbitration (combinational, same cycle):
  - Only a_valid: a_ready=1.
  - Only b_valid: b_ready=1.
  - Both valid: grant the port not granted last (round-robin).
  - Never both readies high in one cycle. Ready is 0 when the port's valid is 0.
- Last-grant pointer updates only on a completed handshake (valid&&ready).
- Write latency is one cycle:
  - A handshake in cycle N drives wen/waddr/wdata in cycle N+1; the register file commits at the end of N+1.
  - No handshake in N: wen=0 in N+1, and waddr/wdata hold their previous values.
- Writes to address 0:
  - The handshake completes normally.
  - wen stays 0 in N+1, waddr/wdata still update.
  - No busy bit is touched.
- Requesters hold valid/addr/data stable until ready; the arbiter never drops an asserted, ungranted request.
- Scoreboard (one busy bit per register; bit 0 is hard-wired 0):
  - Set at the clk edge when issue_valid=1 and issue_addr!=0.
  - Cleared at the end of the cycle in which wen=1 for that waddr.
  - Busy is therefore still 1 during the commit cycle, matching the register file's read-before-write timing.
  - Set and clear to the same address in the same cycle: set wins (the newer pending write dominates).
- rs1_busy = busy[raddr1], rs2_busy = busy[raddr2]; both are 0 when the address is 0.
- One busy bit per register, with no counting: decode must not issue a second write to a busy register (it stalls on WAW).
  - The arbiter does not check this; behaviour under violation is unspecified.

Test Plan:
- Reset, then a_valid=1 with a_addr=5, a_data=0x1234 in cycle 1 -> a_ready=1 in cycle 1; wen=1, waddr=5, wdata=0x1234 in cycle 2; wen=0 in cycle 3.
- a_valid and b_valid held high for 4 cycles (a_addr=3, b_addr=4) -> grant order A,B,A,B; wen pulses 4 consecutive cycles alternating waddr 3,4,3,4; the requester whose handshake completed each cycle must present its next request so that both valids stay high.
- issue_valid with issue_addr=7, then raddr1=7 -> rs1_busy=1 from the next cycle; B writes x7 in cycle N -> rs1_busy=1 through N+1, 0 from N+2.
- Same-cycle issue_addr=9 set and wen=1 with waddr=9 -> busy[9] remains 1 afterwards; raddr2=9 gives rs2_busy=1.
- a_valid with a_addr=0, a_data=0xFFFF -> a_ready=1, wen=0 next cycle; raddr1=0 gives rs1_busy=0 even after issue_valid with issue_addr=0.
- Set busy on x1 and x2, assert rst during a pending A request -> wen=0 the following cycle, rs1_busy=rs2_busy=0 for x1/x2, and the next contention grants A first.
